pto_axis_driver: RTL and testbench



---
 rtl/pto_axis_driver_if.sv | 19 +
 rtl/pto_axis_driver.sv | 193 +++++++++++++++++++
 tb/tb_pto_axis_driver.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pto_axis_driver_if.sv
// Avalon-MM register port of the pulse-train axis driver.
// Read data is registered in the slave and returned one clock after avs_read; there is no wait-request.
interface pto_axis_driver_if;
    logic [2:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata
    );
endinterface

// File: rtl/pto_axis_driver.sv
// Step/direction pulse-train generator for one axis, driven by firmware through Avalon-MM registers.
// Read latency 1, pto/motor_dir registered; no backpressure, every access completes in one cycle.
module pto_axis_driver #(
    parameter int CNT_W         = 32,
    parameter int DIR_SETUP_CYC = 50,
    parameter int MIN_HALF      = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    pto_axis_driver_if.slave avs,
    output logic             irq,
    output logic             pto,
    output logic             motor_dir
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_LOW   = 2'd3;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_MIN = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(DIR_SETUP_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             irq_en_q, irq_en_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             pto_q, pto_d;
    logic             mdir_q, mdir_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             wr_ctrl;
    logic             start;
    logic             stop;
    logic             busy;
    logic [CNT_W-1:0] half_eff;

    assign wr_ctrl  = avs.avs_write && (avs.avs_address == 3'd0);
    // STOP in the same write as START suppresses the start.
    assign start    = wr_ctrl && avs.avs_writedata[0] && !avs.avs_writedata[1];
    assign stop     = wr_ctrl && avs.avs_writedata[1];
    assign busy     = (state_q != S_IDLE);
    assign half_eff = (period_q < HALF_MIN) ? HALF_MIN : period_q;

    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        count_d  = count_q;
        rem_d    = rem_q;
        half_d   = half_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        irq_en_d = irq_en_q;
        done_d   = done_q;
        abort_d  = abort_q;
        pto_d    = pto_q;
        mdir_d   = mdir_q;
        rdata_d  = rdata_q;

        if (avs.avs_write) begin
            case (avs.avs_address)
                3'd0: begin
                    dir_d    = avs.avs_writedata[2];
                    irq_en_d = avs.avs_writedata[3];
                end
                3'd1: period_d = avs.avs_writedata[CNT_W-1:0];
                3'd2: count_d  = avs.avs_writedata[CNT_W-1:0];
                3'd3: begin
                    if (avs.avs_writedata[1]) done_d  = 1'b0;
                    if (avs.avs_writedata[2]) abort_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Flag sets below follow the W1C clears so a hardware set wins.
        if (stop && busy) begin
            state_d = S_IDLE;
            pto_d   = 1'b0;
            abort_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mdir_d = avs.avs_writedata[2];
                        rem_d  = count_q;
                        if (count_q == '0) begin
                            done_d = 1'b1;
                        end else if (avs.avs_writedata[2] == mdir_q) begin
                            state_d = S_HIGH;
                            pto_d   = 1'b1;
                            half_d  = half_eff;
                            cnt_d   = half_eff - ONE;
                        end else begin
                            state_d = S_SETUP;
                            cnt_d   = SETUP_LD;
                        end
                    end
                end
                S_SETUP: begin
                    if (cnt_q == '0) begin
                        state_d = S_HIGH;
                        pto_d   = 1'b1;
                        half_d  = half_eff;
                        cnt_d   = half_eff - ONE;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                S_HIGH: begin
                    if (cnt_q == '0) begin
                        state_d = S_LOW;
                        pto_d   = 1'b0;
                        cnt_d   = half_q - ONE;
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
                default: begin
                    if (cnt_q == '0) begin
                        rem_d = rem_q - ONE;
                        if (rem_q == ONE) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_HIGH;
                            pto_d   = 1'b1;
                            half_d  = half_eff;
                            cnt_d   = half_eff - ONE;
                        end
                    end else begin
                        cnt_d = cnt_q - ONE;
                    end
                end
            endcase
        end

        if (avs.avs_read) begin
            case (avs.avs_address)
                3'd1:    rdata_d = 32'(period_q);
                3'd2:    rdata_d = 32'(count_q);
                3'd3:    rdata_d = {29'd0, abort_q, done_q, busy};
                3'd4:    rdata_d = 32'(rem_q);
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q  <= S_IDLE;
            period_q <= '0;
            count_q  <= '0;
            rem_q    <= '0;
            half_q   <= '0;
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            pto_q    <= 1'b0;
            mdir_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            half_q   <= half_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            abort_q  <= abort_d;
            pto_q    <= pto_d;
            mdir_q   <= mdir_d;
            rdata_q  <= rdata_d;
        end
    end

    assign avs.avs_readdata = rdata_q;
    assign pto              = pto_q;
    assign motor_dir        = mdir_q;
    assign irq              = irq_en_q & (done_q | abort_q);

endmodule

// File: tb/tb_pto_axis_driver.sv
// Directed bench for pto_axis_driver: expected reads and output edges are queued as stimulus is issued,
// and a negedge monitor pops and compares them as the DUT produces read data or toggles pto/motor_dir/irq.
module tb_pto_axis_driver;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic irq, pto, motor_dir;

    pto_axis_driver_if bus ();

    pto_axis_driver dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .avs           (bus),
        .irq           (irq),
        .pto           (pto),
        .motor_dir     (motor_dir)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int t;

    logic [31:0] rd_exp_q[$];
    string       rd_nm_q[$];
    int          pto_ev_q[$];
    int          dir_ev_q[$];
    int          irq_ev_q[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Edge entries are encoded as cycle*2 + new level.
    task automatic ev_cmp(input string nm, input bit have, input int exp, input logic lvl);
        n_cmp++;
        if (!have) begin
            n_err++;
            $display("FAIL %s edge: got level %0b at cyc %0d, expected no edge", nm, lvl, cyc);
        end else if (exp != cyc * 2 + int'(lvl)) begin
            n_err++;
            $display("FAIL %s edge: got level %0b at cyc %0d, expected level %0d at cyc %0d",
                     nm, lvl, cyc, exp % 2, exp / 2);
        end
    endtask

    logic rd_vld = 1'b0;
    always @(posedge clk) rd_vld <= bus.avs_read;

    logic pto_prev = 1'b0, dir_prev = 1'b0, irq_prev = 1'b0;
    always @(negedge clk) begin
        if (rd_vld) begin
            if (rd_exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL read_unexpected: got 0x%0h, expected no read data", bus.avs_readdata);
            end else begin
                check(rd_nm_q.pop_front(), bus.avs_readdata, rd_exp_q.pop_front());
            end
        end
        if (pto !== pto_prev) begin
            if (pto_ev_q.size() > 0) ev_cmp("pto", 1'b1, pto_ev_q.pop_front(), pto);
            else                     ev_cmp("pto", 1'b0, 0, pto);
        end
        if (motor_dir !== dir_prev) begin
            if (dir_ev_q.size() > 0) ev_cmp("motor_dir", 1'b1, dir_ev_q.pop_front(), motor_dir);
            else                     ev_cmp("motor_dir", 1'b0, 0, motor_dir);
        end
        if (irq !== irq_prev) begin
            if (irq_ev_q.size() > 0) ev_cmp("irq", 1'b1, irq_ev_q.pop_front(), irq);
            else                     ev_cmp("irq", 1'b0, 0, irq);
        end
        pto_prev = pto;
        dir_prev = motor_dir;
        irq_prev = irq;
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        @(negedge clk);
        bus.avs_write     = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string nm);
        rd_exp_q.push_back(exp);
        rd_nm_q.push_back(nm);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        @(negedge clk);
        bus.avs_read    = 1'b0;
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic exp_pulses(input int t0, input int half, input int n);
        for (int k = 0; k < n; k++) begin
            pto_ev_q.push_back((t0 + 2 * half * k) * 2 + 1);
            pto_ev_q.push_back((t0 + 2 * half * k + half) * 2);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.avs_address   = '0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = '0;
        bus.avs_read      = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_pto",       32'(pto),       32'd0);
        check("rst_motor_dir", 32'(motor_dir), 32'd0);
        check("rst_irq",       32'(irq),       32'd0);
        check("rst_readdata",  bus.avs_readdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        rd(3'd3, 32'd0, "rst_status");
        rd(3'd1, 32'd0, "rst_period");
        rd(3'd4, 32'd0, "rst_remaining");

        // Single move, same direction: 3 pulses of 5 high / 5 low.
        wr(3'd1, 32'd5);
        wr(3'd2, 32'd3);
        t = cyc + 1;
        exp_pulses(t, 5, 3);
        wr(3'd0, 32'h1);
        wait_to(t + 14);
        rd(3'd4, 32'd2, "t1_remaining_mid");
        wait_to(t + 29);
        rd(3'd3, 32'd1, "t1_busy_last_cycle");
        rd(3'd3, 32'd2, "t1_done");
        rd(3'd4, 32'd0, "t1_remaining_end");
        wr(3'd3, 32'h2);
        rd(3'd3, 32'd0, "t1_w1c_done");

        // Direction change inserts the 50-clock setup.
        wr(3'd1, 32'd4);
        wr(3'd2, 32'd1);
        t = cyc + 1;
        dir_ev_q.push_back(t * 2 + 1);
        exp_pulses(t + 50, 4, 1);
        wr(3'd0, 32'h5);
        rd(3'd3, 32'd1, "t2_busy_setup_start");
        wait_to(t + 24);
        rd(3'd3, 32'd1, "t2_busy_setup_mid");
        wait_to(t + 57);
        rd(3'd3, 32'd1, "t2_busy_last_cycle");
        rd(3'd3, 32'd2, "t2_done");
        wr(3'd3, 32'h2);

        // PERIOD=0 clamps to 2.
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd2);
        t = cyc + 1;
        exp_pulses(t, 2, 2);
        wr(3'd0, 32'h5);
        rd(3'd1, 32'd0, "t3_period_raw");
        wait_to(t + 7);
        rd(3'd3, 32'd1, "t3_busy_last_cycle");
        rd(3'd3, 32'd2, "t3_done_clamped");
        wr(3'd3, 32'h2);

        // COUNT=0: done immediately, no pulse.
        wr(3'd2, 32'd0);
        wr(3'd0, 32'h5);
        rd(3'd3, 32'd2, "t3_zero_count_done");
        rd(3'd4, 32'd0, "t3_zero_count_rem");
        wr(3'd3, 32'h2);
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, 32'd0, "unmapped_read");
        rd(3'd0, 32'd0, "ctrl_read_zero");

        // STOP while idle, and START+STOP together.
        wr(3'd2, 32'd1);
        wr(3'd0, 32'h6);
        rd(3'd3, 32'd0, "stop_idle_noeffect");
        wr(3'd0, 32'h7);
        rd(3'd3, 32'd0, "start_stop_same_write");

        // Abort in the HIGH phase of the 7th pulse.
        wr(3'd1, 32'd10);
        wr(3'd2, 32'd100);
        t = cyc + 1;
        exp_pulses(t, 10, 6);
        pto_ev_q.push_back((t + 120) * 2 + 1);
        pto_ev_q.push_back((t + 123) * 2);
        wr(3'd0, 32'h5);
        wait_to(t + 122);
        wr(3'd0, 32'h6);
        rd(3'd3, 32'd4, "t4_aborted");
        rd(3'd4, 32'd94, "t4_remaining");
        wr(3'd1, 32'd2);
        wr(3'd2, 32'd1);
        t = cyc + 1;
        exp_pulses(t, 2, 1);
        wr(3'd0, 32'h5);
        wait_to(t + 5);
        rd(3'd3, 32'd6, "t4_restart_done");
        wr(3'd3, 32'h6);
        rd(3'd3, 32'd0, "t4_w1c_both");

        // IRQ, mid-move PERIOD change, ignored START while busy.
        wr(3'd1, 32'd3);
        wr(3'd2, 32'd2);
        t = cyc + 1;
        exp_pulses(t, 3, 1);
        exp_pulses(t + 6, 20, 1);
        irq_ev_q.push_back((t + 46) * 2 + 1);
        wr(3'd0, 32'hD);
        wait_to(t + 1);
        wr(3'd1, 32'd20);
        wait_to(t + 3);
        wr(3'd0, 32'hD);
        wait_to(t + 47);
        rd(3'd4, 32'd0, "t5_remaining_end");
        t = cyc + 1;
        irq_ev_q.push_back(t * 2);
        wr(3'd3, 32'h2);
        rd(3'd3, 32'd0, "t5_status_cleared");

        // Asynchronous reset in the middle of a HIGH phase.
        wr(3'd1, 32'd5);
        wr(3'd2, 32'd5);
        t = cyc + 1;
        pto_ev_q.push_back(t * 2 + 1);
        wr(3'd0, 32'h5);
        wait_to(t + 2);
        pto_ev_q.push_back((t + 3) * 2);
        dir_ev_q.push_back((t + 3) * 2);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd(3'd3, 32'd0, "t6_status_after_rst");
        rd(3'd1, 32'd0, "t6_period_after_rst");
        rd(3'd4, 32'd0, "t6_remaining_after_rst");
        repeat (20) @(negedge clk);

        check("leftover_reads",     32'(rd_exp_q.size()), 32'd0);
        check("leftover_pto_edges", 32'(pto_ev_q.size()), 32'd0);
        check("leftover_dir_edges", 32'(dir_ev_q.size()), 32'd0);
        check("leftover_irq_edges", 32'(irq_ev_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
